// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//
// Shared encodings for the multicycle control path:
//   - state_t       : the twelve FSM states of multicycle_ctrl_fsm
//   - OP_*          : primary opcodes (instr[31:26]) the controller recognises
//   - FN_*          : R-type funct codes (instr[5:0])
//   - ALU_*         : ALUControl codes, shared with the ALU in the datapath
//   - ALUOP_*       : coarse ALU request from the FSM to alu_decoder
//   - ctrl_t        : the per-state control word decoded from the state
//   - op_known()    : true for every opcode the FSM can sequence
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // Primary opcodes
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl codes understood by the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Mux select encodings
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;

    // Everything the state decode produces, before reset gating.
    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_known(input logic [5:0] op);
        logic known;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: known = 1'b1;
            default:                                       known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
//
// Purely combinational translation of the FSM's coarse ALU request into the
// 3-bit ALUControl code, plus a validity flag for the R-type funct field.
//
// Ports:
//   ALUOp       in  2  00 add, 01 sub, 10 decode from Funct
//   Funct       in  6  instr[5:0]
//   ALUControl  out 3  ALU operation code (ALU_* in ctrl_pkg)
//   funct_valid out 1  Funct is one of the supported R-type operations;
//                      independent of ALUOp so DECODE can screen R-types
// ----------------------------------------------------------------------------
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl,
    output logic       funct_valid
);

    logic [2:0] funct_alu;

    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path through the case leaves it holding its old value (a latch).
    always_comb begin
        funct_alu   = ALU_ADD;
        funct_valid = 1'b1;
        case (Funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: ALUControl = funct_alu;
            default:     ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Moore control FSM for the multicycle datapath. Sequences fetch, decode,
// execute, memory and writeback for lw, sw, R-type (add/sub/and/or/slt),
// beq, addi and j, and drives every mux select and write enable.
//
// Ports:
//   clk         in  1  single clock, all state updates on posedge
//   reset       in  1  synchronous, active-high
//   Op          in  6  instr[31:26] from the IR
//   Funct       in  6  instr[5:0]
//   Zero        in  1  ALU zero flag, only consulted in BEQEX
//   ALUControl  out 3  ALU operation code
//   ALUSrcA     out 1  0 = PC, 1 = A
//   ALUSrcB     out 2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   IorD        out 1  memory address: 0 = PC, 1 = ALUOut
//   RegDst      out 1  0 = rt, 1 = rd
//   MemtoReg    out 1  0 = ALUOut, 1 = memory data
//   PCSrc       out 2  00 = ALUResult, 01 = ALUOut, 10 = jump target
//   IRWrite     out 1  instruction register write enable
//   MemWrite    out 1  data memory write enable
//   RegWrite    out 1  register file write enable
//   PCEn        out 1  PC write enable: PCWrite | (Branch & Zero)
//   instr_done  out 1  pulse in the last state of each legal instruction
//   illegal_op  out 1  pulse in a DECODE cycle that sees an unknown Op/funct
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCEn,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state;
    state_t state_next;
    ctrl_t  ctl;
    logic   funct_valid;
    logic   illegal_decode;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignment so every flop samples
    // its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Illegal instruction screen. Only meaningful in DECODE, where the IR
    // holds the freshly fetched word. An R-type is rejected here rather than
    // in RTYPEEX so that no writeback is ever scheduled for it.
    // ------------------------------------------------------------------------
    always_comb begin
        illegal_decode = 1'b0;
        if (state == S_DECODE) begin
            illegal_decode = !op_known(Op) || ((Op == OP_RTYPE) && !funct_valid);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (illegal_decode) begin
                    state_next = S_FETCH;
                end else begin
                    case (Op)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_RTYPE:     state_next = S_RTYPEEX;
                        OP_BEQ:       state_next = S_BEQEX;
                        OP_ADDI:      state_next = S_ADDIEX;
                        OP_J:         state_next = S_JEX;
                        default:      state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            // MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX all return to FETCH.
            default:   state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore output decode: a control word per state, all-zero by default.
    // ------------------------------------------------------------------------
    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.ir_write  = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                // Branch target PC+4+(imm<<2) is computed speculatively into ALUOut.
                ctl.alu_src_b = SRCB_IMMSH;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctl.iord       = 1'b1;
                ctl.mem_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_RTYPEEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                ctl.alu_src_a  = 1'b1;
                ctl.alu_op     = ALUOP_SUB;
                ctl.branch     = 1'b1;
                ctl.pc_src     = PCSRC_ALUOUT;
                ctl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_JEX: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PCSRC_JUMP;
                ctl.instr_done = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp       (ctl.alu_op),
        .Funct       (Funct),
        .ALUControl  (ALUControl),
        .funct_valid (funct_valid)
    );

    // ------------------------------------------------------------------------
    // Outputs. Reset masks every write enable and pulse combinationally so an
    // instruction interrupted by reset cannot commit anything, whatever state
    // the register happens to hold in that cycle.
    // ------------------------------------------------------------------------
    assign ALUSrcA    = ctl.alu_src_a;
    assign ALUSrcB    = ctl.alu_src_b;
    assign IorD       = ctl.iord;
    assign RegDst     = ctl.reg_dst;
    assign MemtoReg   = ctl.mem_to_reg;
    assign PCSrc      = ctl.pc_src;

    assign IRWrite    = ctl.ir_write   & ~reset;
    assign MemWrite   = ctl.mem_write  & ~reset;
    assign RegWrite   = ctl.reg_write  & ~reset;
    assign PCEn       = (ctl.pc_write | (ctl.branch & Zero)) & ~reset;
    assign instr_done = ctl.instr_done & ~reset;
    assign illegal_op = illegal_decode & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Directed bench for multicycle_ctrl_fsm. Each clock cycle of each
// instruction is compared against a hand-written expected control vector.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       PCEn;
    logic       instr_done;
    logic       illegal_op;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .IorD       (IorD),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .PCSrc      (PCSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCEn       (PCEn),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    // Full observed control vector, 17 bits.
    logic [16:0] outs;
    assign outs = {ALUControl, ALUSrcA, ALUSrcB, IorD, RegDst, MemtoReg, PCSrc,
                   IRWrite, MemWrite, RegWrite, PCEn, instr_done, illegal_op};

    // Enables/pulses that reset must force low.
    logic [5:0] enables;
    assign enables = {IRWrite, MemWrite, RegWrite, PCEn, instr_done, illegal_op};

    function automatic logic [16:0] mk(
        input logic [2:0] alu, input logic srca, input logic [1:0] srcb,
        input logic iord, input logic regdst, input logic memtoreg,
        input logic [1:0] pcsrc, input logic ir, input logic mw, input logic rw,
        input logic pcen, input logic done, input logic ill);
        return {alu, srca, srcb, iord, regdst, memtoreg, pcsrc, ir, mw, rw, pcen, done, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] observed, input logic [16:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, observed, expected);
        end
    endtask

    // Compare one cycle's outputs, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [16:0] expected);
        @(negedge clk);
        check(tag, outs, expected);
        @(posedge clk);
        #1;
    endtask

    logic [16:0] e_fetch, e_decode, e_decode_ill, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [16:0] e_rtwb, e_addiex, e_addiwb, e_jex;

    initial begin
        //                alu    sa sb     io rd mr pcs    ir mw rw pe dn il
        e_fetch      = mk(3'b000,0, 2'b01, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0);
        e_decode     = mk(3'b000,0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        e_decode_ill = mk(3'b000,0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        e_memadr     = mk(3'b000,1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        e_memrd      = mk(3'b000,0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        e_memwb      = mk(3'b000,0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 1, 0, 1, 0);
        e_memwr      = mk(3'b000,0, 2'b00, 1, 0, 0, 2'b00, 0, 1, 0, 0, 1, 0);
        e_rtwb       = mk(3'b000,0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 1, 0, 1, 0);
        e_addiex     = mk(3'b000,1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        e_addiwb     = mk(3'b000,0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0);
        e_jex        = mk(3'b000,0, 2'b00, 0, 0, 0, 2'b10, 0, 0, 0, 1, 1, 0);

        // 1. Reset for two cycles: all enables and pulses low.
        reset = 1'b1;
        Op    = 6'b100011;
        Funct = 6'b000000;
        Zero  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset.enables", {11'd0, enables}, 17'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        // 2. lw: 5 cycles, writeback only in the fifth.
        Zero = 1'b0;
        cyc("lw.fetch",  e_fetch);
        cyc("lw.decode", e_decode);
        cyc("lw.memadr", e_memadr);
        cyc("lw.memrd",  e_memrd);
        cyc("lw.memwb",  e_memwb);

        // 3. R-type slt, then R-type and.
        Op    = 6'b000000;
        Funct = 6'b101010;
        cyc("slt.fetch",  e_fetch);
        cyc("slt.decode", e_decode);
        cyc("slt.ex",     mk(3'b101,1,2'b00,0,0,0,2'b00,0,0,0,0,0,0));
        cyc("slt.wb",     e_rtwb);
        Funct = 6'b100100;
        cyc("and.fetch",  e_fetch);
        cyc("and.decode", e_decode);
        cyc("and.ex",     mk(3'b010,1,2'b00,0,0,0,2'b00,0,0,0,0,0,0));
        cyc("and.wb",     e_rtwb);

        // 4. beq taken (Zero held high also through DECODE, where it is ignored).
        Op    = 6'b000100;
        Funct = 6'b000000;
        Zero  = 1'b1;
        cyc("beqt.fetch",  e_fetch);
        cyc("beqt.decode", e_decode);
        cyc("beqt.ex",     mk(3'b001,1,2'b00,0,0,0,2'b01,0,0,0,1,1,0));
        // beq not taken
        Zero = 1'b0;
        cyc("beqn.fetch",  e_fetch);
        cyc("beqn.decode", e_decode);
        cyc("beqn.ex",     mk(3'b001,1,2'b00,0,0,0,2'b01,0,0,0,0,1,0));

        // sw, addi, j
        Op = 6'b101011;
        cyc("sw.fetch",  e_fetch);
        cyc("sw.decode", e_decode);
        cyc("sw.memadr", e_memadr);
        cyc("sw.memwr",  e_memwr);
        Op = 6'b001000;
        cyc("addi.fetch",  e_fetch);
        cyc("addi.decode", e_decode);
        cyc("addi.ex",     e_addiex);
        cyc("addi.wb",     e_addiwb);
        Op = 6'b000010;
        cyc("j.fetch",  e_fetch);
        cyc("j.decode", e_decode);
        cyc("j.ex",     e_jex);

        // 5. Illegal opcode, then illegal R-type funct: back to FETCH.
        Op = 6'b111111;
        cyc("illop.fetch",  e_fetch);
        cyc("illop.decode", e_decode_ill);
        Op    = 6'b000000;
        Funct = 6'b000111;
        cyc("illfn.fetch",  e_fetch);
        cyc("illfn.decode", e_decode_ill);
        Funct = 6'b100000;
        cyc("after_ill.fetch", e_fetch);
        cyc("add.decode",      e_decode);
        cyc("add.ex",          mk(3'b000,1,2'b00,0,0,0,2'b00,0,0,0,0,0,0));
        cyc("add.wb",          e_rtwb);

        // 6. Reset pulse while in MEMWR: write suppressed, restart at FETCH.
        Op = 6'b101011;
        cyc("swr.fetch",  e_fetch);
        cyc("swr.decode", e_decode);
        cyc("swr.memadr", e_memadr);
        reset = 1'b1;
        @(negedge clk);
        check("swr.memwrite_in_reset", {16'd0, MemWrite}, 17'd0);
        check("swr.enables_in_reset",  {11'd0, enables}, 17'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("swr.refetch", e_fetch);
        cyc("swr.redecode", e_decode);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
